// File: rtl/seg_scan_mux.sv
// seg_scan_mux: time-multiplexed driver for a common-anode N-digit
// seven-segment display. It scans one digit per slot onto a shared
// active-low segment bus and drives one-cold digit enables. Each slot
// starts with a dead window to suppress ghosting. Pattern, blanking and
// brightness are latched at slot start, so the display never tears.
// Brightness is applied by comparing it against a free-running PWM
// counter. A frame_tick pulse marks the first output cycle of slot 0.
module seg_scan_mux #(
    parameter int NUM_DIGITS  = 4,
    parameter int SEG_W       = 8,
    parameter int REFRESH_DIV = 50000,
    parameter int DEAD_CYCLES = 16,
    parameter int BRIGHT_W    = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_DIGITS*SEG_W-1:0]   digits_flat,
    input  logic [NUM_DIGITS-1:0]         blank_mask,
    input  logic [BRIGHT_W-1:0]           brightness,
    input  logic                          scan_en,
    output logic [SEG_W-1:0]              out,
    output logic [NUM_DIGITS-1:0]         enable,
    output logic [$clog2(NUM_DIGITS)-1:0] digit_idx,
    output logic                          frame_tick
);

    localparam int IDX_W = $clog2(NUM_DIGITS);
    localparam int CNT_W = $clog2(REFRESH_DIV);

    localparam logic [CNT_W-1:0] SLOT_LAST  = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0] DEAD_LIMIT = CNT_W'(DEAD_CYCLES);
    localparam logic [IDX_W-1:0] DIGIT_LAST = IDX_W'(NUM_DIGITS - 1);

    // Parameter legality is checked at elaboration, so a bad configuration
    // never reaches hardware.
    if (NUM_DIGITS < 2 || NUM_DIGITS > 16) begin : g_bad_num_digits
        $error("seg_scan_mux: NUM_DIGITS must be in 2..16");
    end
    if (REFRESH_DIV <= DEAD_CYCLES + 1) begin : g_bad_refresh_div
        $error("seg_scan_mux: REFRESH_DIV must exceed DEAD_CYCLES+1");
    end

    // Scan state.
    logic [CNT_W-1:0]    slot_cnt_q,  slot_cnt_d;
    logic [IDX_W-1:0]    digit_idx_q, digit_idx_d;
    logic [BRIGHT_W-1:0] pwm_cnt_q,   pwm_cnt_d;

    // Values held for the whole slot.
    logic [SEG_W-1:0]    pat_l_q,    pat_l_d;
    logic                blank_l_q,  blank_l_d;
    logic [BRIGHT_W-1:0] bright_l_q, bright_l_d;

    // Registered outputs.
    logic [SEG_W-1:0]      out_q,        out_d;
    logic [NUM_DIGITS-1:0] enable_q,     enable_d;
    logic                  frame_tick_q, frame_tick_d;

    // Slot-level decode.
    logic                slot_start;
    logic                slot_wrap;
    logic [SEG_W-1:0]    cur_pattern;
    logic [SEG_W-1:0]    pat_eff;
    logic                blank_eff;
    logic [BRIGHT_W-1:0] bright_eff;
    logic                in_live;
    logic                pwm_on;
    logic                lit;

    // Decode the current slot position and the values in force for it.
    always_comb begin
        slot_start  = (slot_cnt_q == '0);
        slot_wrap   = (slot_cnt_q == SLOT_LAST);
        cur_pattern = digits_flat[digit_idx_q*SEG_W +: SEG_W];
        // In the first cycle of a slot the latch is still loading, so the
        // live inputs stand in for it. This keeps a neighbouring digit's
        // pattern off the bus even when DEAD_CYCLES is zero.
        pat_eff    = slot_start ? cur_pattern             : pat_l_q;
        blank_eff  = slot_start ? blank_mask[digit_idx_q] : blank_l_q;
        bright_eff = slot_start ? brightness              : bright_l_q;
        in_live    = (slot_cnt_q >= DEAD_LIMIT);
        // Full scale stays on constantly. Zero never satisfies the compare.
        pwm_on     = (bright_eff == '1) || (pwm_cnt_q < bright_eff);
        lit        = scan_en && in_live && !blank_eff && pwm_on;
    end

    // Next-state logic for the scan counters and the slot-start latch.
    always_comb begin
        // NOTE: every always_comb output gets a default before any branch, so
        // no path can leave a value unassigned and infer a latch.
        slot_cnt_d  = slot_cnt_q;
        digit_idx_d = digit_idx_q;
        pwm_cnt_d   = pwm_cnt_q;
        pat_l_d     = pat_l_q;
        blank_l_d   = blank_l_q;
        bright_l_d  = bright_l_q;

        if (!scan_en) begin
            slot_cnt_d  = '0;
            digit_idx_d = '0;
            pwm_cnt_d   = '0;
        end else begin
            pwm_cnt_d = pwm_cnt_q + 1'b1;
            if (slot_wrap) begin
                slot_cnt_d  = '0;
                digit_idx_d = (digit_idx_q == DIGIT_LAST) ? '0 : digit_idx_q + 1'b1;
            end else begin
                slot_cnt_d = slot_cnt_q + 1'b1;
            end
        end

        if (slot_start) begin
            pat_l_d    = cur_pattern;
            blank_l_d  = blank_mask[digit_idx_q];
            bright_l_d = brightness;
        end
    end

    // Next values for the registered display outputs.
    always_comb begin
        out_d    = '1;
        enable_d = '1;
        if (lit) begin
            out_d                 = pat_eff;
            enable_d[digit_idx_q] = 1'b0;
        end
        frame_tick_d = scan_en && slot_start && (digit_idx_q == '0);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only. Every
        // register then samples values from before the edge, whatever order
        // the statements are written in.
        if (rst) begin
            slot_cnt_q   <= '0;
            digit_idx_q  <= '0;
            pwm_cnt_q    <= '0;
            pat_l_q      <= '1;
            blank_l_q    <= 1'b0;
            bright_l_q   <= '0;
            out_q        <= '1;
            enable_q     <= '1;
            frame_tick_q <= 1'b0;
        end else begin
            slot_cnt_q   <= slot_cnt_d;
            digit_idx_q  <= digit_idx_d;
            pwm_cnt_q    <= pwm_cnt_d;
            pat_l_q      <= pat_l_d;
            blank_l_q    <= blank_l_d;
            bright_l_q   <= bright_l_d;
            out_q        <= out_d;
            enable_q     <= enable_d;
            frame_tick_q <= frame_tick_d;
        end
    end

    assign out        = out_q;
    assign enable     = enable_q;
    assign digit_idx  = digit_idx_q;
    assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_seg_scan_mux.sv
// Bench for seg_scan_mux. It runs a 4-digit and a 3-digit instance side by
// side from the same stimulus. Before each clock edge it pushes the expected
// outputs onto a scoreboard, and after the edge it pops and compares them.
module tb_seg_scan_mux;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        scan_en;
    logic [31:0] digits;
    logic [3:0]  mask;
    logic [1:0]  bright;

    logic [7:0] out4;
    logic [3:0] en4;
    logic [1:0] idx4;
    logic       ft4;
    logic [7:0] out3;
    logic [2:0] en3;
    logic [1:0] idx3;
    logic       ft3;

    seg_scan_mux #(
        .NUM_DIGITS(4), .SEG_W(8), .REFRESH_DIV(8), .DEAD_CYCLES(2), .BRIGHT_W(2)
    ) dut (
        .clk(clk), .rst(rst), .digits_flat(digits), .blank_mask(mask),
        .brightness(bright), .scan_en(scan_en), .out(out4), .enable(en4),
        .digit_idx(idx4), .frame_tick(ft4)
    );

    seg_scan_mux #(
        .NUM_DIGITS(3), .SEG_W(8), .REFRESH_DIV(8), .DEAD_CYCLES(2), .BRIGHT_W(2)
    ) dut3 (
        .clk(clk), .rst(rst), .digits_flat(digits[23:0]), .blank_mask(mask[2:0]),
        .brightness(bright), .scan_en(scan_en), .out(out3), .enable(en3),
        .digit_idx(idx3), .frame_tick(ft3)
    );

    typedef struct {
        logic [3:0] en4;
        logic [7:0] out4;
        logic       ft4;
        logic [1:0] idx4;
        logic [2:0] en3;
        logic [7:0] out3;
        logic       ft3;
        logic [1:0] idx3;
    } exp_t;

    exp_t sb[$];

    int total  = 0;
    int passed = 0;

    // Reference state: position in the scan since the last restart, and the
    // slot-start latch of each instance.
    int         pos4 = 0, pos3 = 0;
    logic [7:0] lp4 = 8'hFF, lp3 = 8'hFF;
    logic       lb4 = 1'b0,  lb3 = 1'b0;
    logic [1:0] lr4 = 2'd0,  lr3 = 2'd0;

    int lit4_cnt = 0, ft4_cnt = 0, lit3_cnt = 0;
    logic [2:0] en3_seen = 3'b000;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
        total++;
        assert (obs === want) begin
            passed++;
        end else begin
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, want);
        end
    endtask

    // Expected outputs after the coming edge for an nd-digit instance with
    // REFRESH_DIV=8, DEAD_CYCLES=2 and 2-bit brightness.
    task automatic model(input int nd, inout int pos, inout logic [7:0] lpat,
                         inout logic lblank, inout logic [1:0] lbr,
                         output logic [3:0] en, output logic [7:0] seg,
                         output logic ft, output logic [1:0] idx);
        int   slot, dig, pwm;
        logic lit;
        en  = 4'hF;
        seg = 8'hFF;
        ft  = 1'b0;
        idx = 2'd0;
        if (rst || !scan_en) begin
            pos = 0;
        end else begin
            slot = pos % 8;
            dig  = (pos / 8) % nd;
            pwm  = pos % 4;
            if (slot == 0) begin
                lpat   = digits[dig*8 +: 8];
                lblank = mask[dig];
                lbr    = bright;
            end
            lit = (slot >= 2) && !lblank && ((lbr == 2'd3) || (pwm < int'(lbr)));
            if (lit) begin
                en[dig] = 1'b0;
                seg     = lpat;
            end
            ft  = (slot == 0) && (dig == 0);
            idx = 2'(((pos + 1) / 8) % nd);
            pos++;
        end
    endtask

    task automatic step();
        exp_t       e;
        logic [3:0] en3x;
        model(4, pos4, lp4, lb4, lr4, e.en4, e.out4, e.ft4, e.idx4);
        model(3, pos3, lp3, lb3, lr3, en3x, e.out3, e.ft3, e.idx3);
        e.en3 = en3x[2:0];
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check("enable4",     32'(en4),  32'(e.en4));
        check("out4",        32'(out4), 32'(e.out4));
        check("frame_tick4", 32'(ft4),  32'(e.ft4));
        check("digit_idx4",  32'(idx4), 32'(e.idx4));
        check("enable3",     32'(en3),  32'(e.en3));
        check("out3",        32'(out3), 32'(e.out3));
        check("frame_tick3", 32'(ft3),  32'(e.ft3));
        check("digit_idx3",  32'(idx3), 32'(e.idx3));
        if (en4 != 4'hF) lit4_cnt++;
        if (ft4)         ft4_cnt++;
        if (en3 != 3'h7) lit3_cnt++;
        en3_seen = en3_seen | ~en3;
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    int seq[$];
    int prev;

    initial begin
        rst     = 1'b1;
        scan_en = 1'b1;
        digits  = 32'h4433_2211;
        mask    = 4'b0000;
        bright  = 2'd3;

        // Reset state.
        run(2);
        check("rst_enable", 32'(en4),  32'hF);
        check("rst_out",    32'(out4), 32'hFF);
        rst = 1'b0;

        // Scan order over two frames: 6 lit cycles in each of 8 slots, and
        // one frame tick per 32 cycles.
        lit4_cnt = 0;
        ft4_cnt  = 0;
        run(64);
        check("scan_lit_cycles", 32'(lit4_cnt), 32'd48);
        check("scan_frame_ticks", 32'(ft4_cnt), 32'd2);

        // Blanking digit 2 removes its 6 lit cycles.
        mask     = 4'b0100;
        lit4_cnt = 0;
        run(32);
        check("blank_lit_cycles", 32'(lit4_cnt), 32'd18);

        // Brightness 0 keeps the display dark for the whole frame.
        mask     = 4'b0000;
        bright   = 2'd0;
        lit4_cnt = 0;
        run(32);
        check("bright0_lit_cycles", 32'(lit4_cnt), 32'd0);

        // PWM: within slot positions 2..7, brightness 1 lights only where
        // pwm_cnt==0 (1 per slot), and brightness 2 lights 2 per slot.
        bright   = 2'd1;
        lit4_cnt = 0;
        run(32);
        check("pwm1_lit_cycles", 32'(lit4_cnt), 32'd4);
        bright   = 2'd2;
        lit4_cnt = 0;
        run(32);
        check("pwm2_lit_cycles", 32'(lit4_cnt), 32'd8);
        bright   = 2'd3;

        // Mid-slot pattern change on digit 1 is held off until its next slot.
        run(11);
        digits[15:8] = 8'h5A;
        run(2);
        check("latch_hold_out",    32'(out4), 32'h22);
        check("latch_hold_enable", 32'(en4),  32'hD);
        run(30);
        check("latch_new_out",    32'(out4), 32'h5A);
        check("latch_new_enable", 32'(en4),  32'hD);

        // Reset in the middle of digit 2's slot.
        while (pos4 % 32 != 19) step();
        rst = 1'b1;
        step();
        check("midrst_enable", 32'(en4),  32'hF);
        check("midrst_out",    32'(out4), 32'hFF);
        check("midrst_idx",    32'(idx4), 32'd0);
        rst = 1'b0;
        step();
        check("post_rst_tick", 32'(ft4), 32'd1);
        run(2);
        check("post_rst_enable", 32'(en4),  32'hE);
        check("post_rst_out",    32'(out4), 32'h11);

        // scan_en low for 5 cycles, then the scan restarts at slot 0.
        run(5);
        scan_en = 1'b0;
        run(5);
        check("scan_off_enable", 32'(en4), 32'hF);
        check("scan_off_idx",    32'(idx4), 32'd0);
        scan_en = 1'b1;
        step();
        check("scan_on_tick", 32'(ft4), 32'd1);
        run(2);
        check("scan_on_enable", 32'(en4), 32'hE);

        // Three-digit instance: the index sequence is 0,1,2,0.
        seq.delete();
        prev = -1;
        for (int i = 0; i < 30; i++) begin
            step();
            if (int'(idx3) != prev) seq.push_back(int'(idx3));
            prev = int'(idx3);
        end
        check("nd3_seq_len", 32'(seq.size() >= 4), 32'd1);
        if (seq.size() >= 4) begin
            check("nd3_seq0", 32'(seq[0]), 32'd0);
            check("nd3_seq1", 32'(seq[1]), 32'd1);
            check("nd3_seq2", 32'(seq[2]), 32'd2);
            check("nd3_seq3", 32'(seq[3]), 32'd0);
        end

        // Three-digit frame: all three slots are lit, 6 cycles each.
        while (pos3 % 24 != 0) step();
        lit3_cnt = 0;
        en3_seen = 3'b000;
        run(24);
        check("nd3_lit_cycles", 32'(lit3_cnt), 32'd18);
        check("nd3_digits_seen", 32'(en3_seen), 32'h7);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
